dma_controller: RTL



---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_regfile.sv | 105 ++++++++++
 rtl/dma_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA engine: register map,
// CTRL/STATUS bit positions and the transfer FSM state encoding.
package dma_pkg;

    localparam logic [7:0] OFS_SRC    = 8'h00;
    localparam logic [7:0] OFS_DST    = 8'h01;
    localparam logic [7:0] OFS_COUNT  = 8'h02;
    localparam logic [7:0] OFS_CTRL   = 8'h03;
    localparam logic [7:0] OFS_STATUS = 8'h04;

    localparam int CTRL_START   = 0;
    localparam int CTRL_SRC_INC = 1;
    localparam int CTRL_DST_INC = 2;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_ABORT   = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        RD      = 3'd2,
        RDW     = 3'd3,
        WR      = 3'd4,
        DONE_ST = 3'd5
    } dma_state_t;

endpackage

// File: rtl/dma_regfile.sv
// DMA slave register file: decode, programmed registers, START/ABORT pulses
// and DONE/IRQ flags. Interrupt logic exists only when DMA_IRQ_EN is defined.
module dma_regfile
    import dma_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [7:0]      ADDRESS,
    input  logic [BITS-1:0] DATA_IN,
    output logic [BITS-1:0] DATA_OUT,
    input  logic            WRb,
    input  logic            busy,
    input  logic            done_set,
    output logic [BITS-1:0] src,
    output logic [BITS-1:0] dst,
    output logic [BITS-1:0] count,
    output logic            src_inc,
    output logic            dst_inc,
    output logic            start,
    output logic            abort,
    output logic            irq
);

    logic [BITS-1:0] src_reg, dst_reg, count_reg;
    logic            src_inc_reg, dst_inc_reg, done_reg;
    logic            wr_ctrl, wr_status;
`ifdef DMA_IRQ_EN
    logic            irq_en_reg;
`endif

    assign wr_ctrl   = !WRb && (ADDRESS == OFS_CTRL);
    assign wr_status = !WRb && (ADDRESS == OFS_STATUS);
    // START/ABORT are combinational so the FSM reacts on the very edge the write lands
    assign start     = wr_ctrl && DATA_IN[CTRL_START] && !busy;
    assign abort     = wr_ctrl && DATA_IN[CTRL_ABORT] && busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src_reg     <= '0;
            dst_reg     <= '0;
            count_reg   <= '0;
            src_inc_reg <= 1'b0;
            dst_inc_reg <= 1'b0;
            done_reg    <= 1'b0;
`ifdef DMA_IRQ_EN
            irq_en_reg  <= 1'b0;
`endif
        end else begin
            if (!WRb && !busy) begin
                case (ADDRESS)
                    OFS_SRC:   src_reg   <= DATA_IN;
                    OFS_DST:   dst_reg   <= DATA_IN;
                    OFS_COUNT: count_reg <= DATA_IN;
                    OFS_CTRL: begin
                        src_inc_reg <= DATA_IN[CTRL_SRC_INC];
                        dst_inc_reg <= DATA_IN[CTRL_DST_INC];
`ifdef DMA_IRQ_EN
                        irq_en_reg  <= DATA_IN[CTRL_IRQ_EN];
`endif
                    end
                    default: ;
                endcase
            end
            if (done_set)
                done_reg <= 1'b1;
            else if (start || (wr_status && DATA_IN[STAT_DONE]))
                done_reg <= 1'b0;
        end
    end

    always_comb begin
        DATA_OUT = '0;
        case (ADDRESS)
            OFS_SRC:   DATA_OUT = src_reg;
            OFS_DST:   DATA_OUT = dst_reg;
            OFS_COUNT: DATA_OUT = count_reg;
            OFS_CTRL: begin
                DATA_OUT[CTRL_SRC_INC] = src_inc_reg;
                DATA_OUT[CTRL_DST_INC] = dst_inc_reg;
`ifdef DMA_IRQ_EN
                DATA_OUT[CTRL_IRQ_EN]  = irq_en_reg;
`endif
            end
            OFS_STATUS: begin
                DATA_OUT[STAT_BUSY] = busy;
                DATA_OUT[STAT_DONE] = done_reg;
            end
            default: ;
        endcase
    end

    assign src     = src_reg;
    assign dst     = dst_reg;
    assign count   = count_reg;
    assign src_inc = src_inc_reg;
    assign dst_inc = dst_inc_reg;
`ifdef DMA_IRQ_EN
    assign irq = done_reg & irq_en_reg;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA: bus request/grant FSM with running
// pointers, word count and data buffer. Optional interrupt via DMA_IRQ_EN.
module dma_controller
    import dma_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WRb,
    output logic                    BUS_REQ,
    input  logic                    BUS_GNT,
    output logic [ADDRESS_BITS-1:0] M_ADDRESS,
    output logic [BITS-1:0]         M_DATA_OUT,
    input  logic [BITS-1:0]         M_DATA_IN,
    output logic                    M_WRb,
    output logic                    IRQ
);

    logic [BITS-1:0]         src, dst, count;
    logic                    src_inc, dst_inc, start, abort, busy, done_set;
    dma_state_t              state_reg;
    logic [ADDRESS_BITS-1:0] src_ptr_reg, dst_ptr_reg, m_address_reg;
    logic [ADDRESS_BITS-1:0] src_ptr_next, dst_ptr_next;
    logic [BITS-1:0]         count_left_reg, data_buf_reg;
    logic                    bus_req_reg, m_wrb_reg;

    dma_regfile #(.BITS(BITS)) u_regfile (
        .CLK      (CLK),
        .RST      (RST),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .WRb      (WRb),
        .busy     (busy),
        .done_set (done_set),
        .src      (src),
        .dst      (dst),
        .count    (count),
        .src_inc  (src_inc),
        .dst_inc  (dst_inc),
        .start    (start),
        .abort    (abort),
        .irq      (IRQ)
    );

    assign busy     = (state_reg != IDLE);
    assign done_set = (state_reg == DONE_ST) && !abort;

    always_comb begin
        src_ptr_next = src_inc ? src_ptr_reg + ADDRESS_BITS'(1) : src_ptr_reg;
        dst_ptr_next = dst_inc ? dst_ptr_reg + ADDRESS_BITS'(1) : dst_ptr_reg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            src_ptr_reg    <= '0;
            dst_ptr_reg    <= '0;
            count_left_reg <= '0;
            data_buf_reg   <= '0;
            bus_req_reg    <= 1'b0;
            m_wrb_reg      <= 1'b1;
            m_address_reg  <= '0;
        end else if (abort) begin
            state_reg   <= IDLE;
            bus_req_reg <= 1'b0;
            m_wrb_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    src_ptr_reg    <= ADDRESS_BITS'(src);
                    dst_ptr_reg    <= ADDRESS_BITS'(dst);
                    count_left_reg <= count;
                    if (count == '0) begin
                        state_reg <= DONE_ST;
                    end else begin
                        state_reg   <= REQ;
                        bus_req_reg <= 1'b1;
                    end
                end
                REQ: if (BUS_GNT) begin
                    state_reg     <= RD;
                    m_address_reg <= src_ptr_reg;
                end
                RD: state_reg <= BUS_GNT ? RDW : REQ;
                // Losing grant before the write leaves pointers untouched, so the word restarts at RD
                RDW: if (!BUS_GNT) begin
                    state_reg <= REQ;
                end else begin
                    state_reg     <= WR;
                    data_buf_reg  <= M_DATA_IN;
                    m_address_reg <= dst_ptr_reg;
                    m_wrb_reg     <= 1'b0;
                end
                WR: begin
                    m_wrb_reg      <= 1'b1;
                    src_ptr_reg    <= src_ptr_next;
                    dst_ptr_reg    <= dst_ptr_next;
                    count_left_reg <= count_left_reg - BITS'(1);
                    if (count_left_reg == BITS'(1)) begin
                        state_reg   <= DONE_ST;
                        bus_req_reg <= 1'b0;
                    end else if (BUS_GNT) begin
                        state_reg     <= RD;
                        m_address_reg <= src_ptr_next;
                    end else begin
                        state_reg <= REQ;
                    end
                end
                DONE_ST: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign BUS_REQ    = bus_req_reg;
    assign M_WRb      = m_wrb_reg;
    assign M_ADDRESS  = m_address_reg;
    assign M_DATA_OUT = data_buf_reg;

endmodule
